output_act_ctrl: RTL and testbench

OUTPUT_ACT_CTRL -- requirements
Module: output_act_ctrl

---
 rtl/output_act_ctrl.sv | 158 +++++++++++++++
 tb/tb_output_act_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_act_ctrl.sv
// Output activation controller: packs activation bytes little-endian into wide words
// and buffers them in a first-word-fall-through FIFO with sticky overflow reporting.
module output_act_ctrl #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH   = 64
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                CLEAR_FIFO,
    input  logic [INPUT_WIDTH-1:0]              OUT_ACT_DATA_IN,
    input  logic                                DATA_VALID,
    output logic                                IN_READY,
    input  logic                                FLUSH,
    input  logic                                FIFO_RD_CMD,
    output logic [OUTPUT_WIDTH-1:0]             FIFO_RD_DATA,
    output logic                                FIFO_EMPTY,
    output logic                                FIFO_FULL,
    output logic [$clog2(FIFO_DEPTH):0]         FIFO_COUNT,
    output logic                                OVERFLOW
);

    localparam int unsigned N  = OUTPUT_WIDTH / INPUT_WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [CW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [OUTPUT_WIDTH-1:0] pack_q, pack_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic                    overflow_q, overflow_d;

    logic                    last_byte;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [OUTPUT_WIDTH-1:0] merged;

    assign last_byte = (byte_cnt_q == CW'(N - 1));
    assign IN_READY  = !(full_q && last_byte);

    // Next-state: packing, flush, FIFO bookkeeping; clear overrides everything.
    always_comb begin
        accept     = DATA_VALID && IN_READY;
        merged     = pack_q;
        push       = 1'b0;
        pop        = 1'b0;
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (byte_cnt_q == CW'(k)) begin
                    merged[k*INPUT_WIDTH +: INPUT_WIDTH] = OUT_ACT_DATA_IN;
                end
            end
        end
        pack_d = merged;

        if (DATA_VALID && !IN_READY) begin
            overflow_d = 1'b1;
        end

        if (accept) begin
            if (last_byte) begin
                push       = 1'b1;
                pack_d     = '0;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
        end

        // A byte that completes the word already pushed it; flush only a true partial.
        if (FLUSH && !(accept && last_byte) && (byte_cnt_q != '0 || accept)) begin
            pack_d     = '0;
            byte_cnt_d = '0;
            if (full_q) begin
                overflow_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end

        pop = FIFO_RD_CMD && !empty_q;

        if (CLEAR_FIFO) begin
            push       = 1'b0;
            pop        = 1'b0;
            pack_d     = '0;
            byte_cnt_d = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == (AW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            byte_cnt_q <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array needs no reset; the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (push && !RESET) begin
            mem[wr_ptr_q] <= merged;
        end
    end

    assign FIFO_RD_DATA = empty_q ? '0 : mem[rd_ptr_q];
    assign FIFO_EMPTY   = empty_q;
    assign FIFO_FULL    = full_q;
    assign FIFO_COUNT   = count_q;
    assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_output_act_ctrl.sv
// Self-checking bench for output_act_ctrl: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_output_act_ctrl;

    localparam int DEPTH = 64;
    localparam int N     = 4;

    logic        CLK = 1'b0;
    logic        RESET, CLEAR_FIFO, DATA_VALID, FLUSH, FIFO_RD_CMD;
    logic [7:0]  OUT_ACT_DATA_IN;
    logic        IN_READY, FIFO_EMPTY, FIFO_FULL, OVERFLOW;
    logic [31:0] FIFO_RD_DATA;
    logic [6:0]  FIFO_COUNT;

    output_act_ctrl #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .CLEAR_FIFO(CLEAR_FIFO),
        .OUT_ACT_DATA_IN(OUT_ACT_DATA_IN), .DATA_VALID(DATA_VALID), .IN_READY(IN_READY),
        .FLUSH(FLUSH), .FIFO_RD_CMD(FIFO_RD_CMD), .FIFO_RD_DATA(FIFO_RD_DATA),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL), .FIFO_COUNT(FIFO_COUNT),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stored words, bytes of the word being built, sticky error.
    logic [31:0] mq[$];
    logic [7:0]  pend[$];
    bit          m_ovf;
    logic [31:0] sb[$];

    typedef struct {
        bit          rst, clr, dv;
        logic [7:0]  d;
        bit          fl, rd;
        int          cnt;
        logic [31:0] rdata;
        bit          ovf, rdy;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit rst, bit clr, bit dv, logic [7:0] d, bit fl, bit rd,
                                int cnt, logic [31:0] rdata, bit ovf, bit rdy);
        vec_t v;
        v.rst = rst; v.clr = clr; v.dv = dv; v.d = d; v.fl = fl; v.rd = rd;
        v.cnt = cnt; v.rdata = rdata; v.ovf = ovf; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] assemble();
        logic [31:0] w = '0;
        for (int k = 0; k < pend.size(); k++) w[k*8 +: 8] = pend[k];
        return w;
    endfunction

    task automatic model_edge();
        logic [31:0] nw = '0;
        bit have = 0, done = 0, full, empty, rdy;
        if (RESET || CLEAR_FIFO) begin
            mq.delete(); pend.delete(); m_ovf = 0;
            return;
        end
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        rdy   = !(full && pend.size() == N - 1);
        if (DATA_VALID && !rdy) m_ovf = 1;
        if (DATA_VALID && rdy) begin
            pend.push_back(OUT_ACT_DATA_IN);
            if (pend.size() == N) begin
                nw = assemble(); have = 1; done = 1; pend.delete();
            end
        end
        if (FLUSH && !done && pend.size() > 0) begin
            if (full) m_ovf = 1;
            else begin nw = assemble(); have = 1; end
            pend.delete();
        end
        if (FIFO_RD_CMD && !empty) void'(mq.pop_front());
        if (have) mq.push_back(nw);
    endtask

    task automatic step(input bit rst, input bit clr, input bit dv, input logic [7:0] d,
                        input bit fl, input bit rd);
        RESET = rst; CLEAR_FIFO = clr; DATA_VALID = dv; OUT_ACT_DATA_IN = d;
        FLUSH = fl; FIFO_RD_CMD = rd;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(FIFO_COUNT), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(FIFO_EMPTY), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(FIFO_FULL),  32'(mq.size() == DEPTH));
        chk({tag, ".rdata"}, FIFO_RD_DATA, (mq.size() > 0) ? mq[0] : 32'h0);
        chk({tag, ".ready"}, 32'(IN_READY), 32'(!(mq.size() == DEPTH && pend.size() == N - 1)));
        chk({tag, ".ovf"},   32'(OVERFLOW),  32'(m_ovf));
    endtask

    task automatic push_words(input int n, input bit record);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int b = 0; b < N; b++) step(0, 0, 1, w[b*8 +: 8], 0, 0);
            if (record) sb.push_back(w);
        end
        step(0, 0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        RESET = 1; CLEAR_FIFO = 0; DATA_VALID = 0; OUT_ACT_DATA_IN = '0; FLUSH = 0; FIFO_RD_CMD = 0;

        //            rst clr dv  d      fl rd  cnt rdata          ovf rdy
        tbl[0]  = mk(1,  0,  0, 8'h00, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[1]  = mk(0,  0,  1, 8'h11, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[2]  = mk(0,  0,  1, 8'h22, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[3]  = mk(0,  0,  1, 8'h33, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[4]  = mk(0,  0,  1, 8'h44, 0, 0, 1, 32'h4433_2211, 0, 1);
        tbl[5]  = mk(0,  0,  0, 8'h00, 0, 1, 0, 32'h0000_0000, 0, 1);
        tbl[6]  = mk(0,  0,  1, 8'hAA, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[7]  = mk(0,  0,  1, 8'hBB, 0, 0, 0, 32'h0000_0000, 0, 1);
        tbl[8]  = mk(0,  0,  0, 8'h00, 1, 0, 1, 32'h0000_BBAA, 0, 1);
        tbl[9]  = mk(0,  0,  0, 8'h00, 1, 0, 1, 32'h0000_BBAA, 0, 1);
        tbl[10] = mk(0,  0,  0, 8'h00, 0, 1, 0, 32'h0000_0000, 0, 1);
        tbl[11] = mk(0,  0,  1, 8'h55, 1, 0, 1, 32'h0000_0055, 0, 1);
        tbl[12] = mk(0,  0,  1, 8'h01, 0, 0, 1, 32'h0000_0055, 0, 1);
        tbl[13] = mk(0,  0,  1, 8'h02, 0, 0, 1, 32'h0000_0055, 0, 1);
        tbl[14] = mk(0,  0,  1, 8'h03, 0, 0, 1, 32'h0000_0055, 0, 1);
        tbl[15] = mk(0,  0,  1, 8'h04, 1, 0, 2, 32'h0000_0055, 0, 1);
        tbl[16] = mk(0,  0,  0, 8'h00, 0, 1, 1, 32'h0403_0201, 0, 1);
        tbl[17] = mk(0,  0,  0, 8'h00, 0, 1, 0, 32'h0000_0000, 0, 1);
        tbl[18] = mk(0,  0,  0, 8'h00, 0, 1, 0, 32'h0000_0000, 0, 1);

        for (int i = 0; i < 19; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].clr, tbl[i].dv, tbl[i].d, tbl[i].fl, tbl[i].rd);
            chk({t, ".count"}, 32'(FIFO_COUNT), 32'(tbl[i].cnt));
            chk({t, ".rdata"}, FIFO_RD_DATA, tbl[i].rdata);
            chk({t, ".ovf"},   32'(OVERFLOW), 32'(tbl[i].ovf));
            chk({t, ".ready"}, 32'(IN_READY), 32'(tbl[i].rdy));
            chk({t, ".empty"}, 32'(FIFO_EMPTY), 32'(tbl[i].cnt == 0));
        end

        // Partial flush while full drops the partial word and flags overflow.
        step(1, 0, 0, 8'h00, 0, 0);
        push_words(DEPTH, 0);
        chk("full.flag", 32'(FIFO_FULL), 32'd1);
        step(0, 0, 1, 8'hC1, 0, 0);
        step(0, 0, 1, 8'hC2, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("fullflush.ovf", 32'(OVERFLOW), 32'd1);
        chk("fullflush.count", 32'(FIFO_COUNT), 32'd64);
        step(0, 0, 1, 8'hC3, 0, 0);
        chk("fullflush.ready1", 32'(IN_READY), 32'd1);
        step(0, 0, 1, 8'hC4, 0, 0);
        step(0, 0, 1, 8'hC5, 0, 0);
        chk("fullflush.ready3", 32'(IN_READY), 32'd0);
        check_model("fullflush");

        // Full, blocked 4th byte, pop reopens input.
        step(0, 1, 0, 8'h00, 0, 0);
        push_words(DEPTH, 0);
        chk("full.count", 32'(FIFO_COUNT), 32'd64);
        chk("full.full", 32'(FIFO_FULL), 32'd1);
        step(0, 0, 1, 8'hD1, 0, 0);
        step(0, 0, 1, 8'hD2, 0, 0);
        step(0, 0, 1, 8'hD3, 0, 0);
        chk("full.ready", 32'(IN_READY), 32'd0);
        chk("full.ovf_before", 32'(OVERFLOW), 32'd0);
        step(0, 0, 1, 8'hD4, 0, 0);
        chk("ovf.flag", 32'(OVERFLOW), 32'd1);
        chk("ovf.count", 32'(FIFO_COUNT), 32'd64);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("pop.ready", 32'(IN_READY), 32'd1);
        chk("pop.count", 32'(FIFO_COUNT), 32'd63);
        check_model("pop");

        // Clear beats a completing byte and a read in the same cycle.
        step(0, 1, 1, 8'hE4, 0, 1);
        chk("clr.empty", 32'(FIFO_EMPTY), 32'd1);
        chk("clr.count", 32'(FIFO_COUNT), 32'd0);
        chk("clr.ovf", 32'(OVERFLOW), 32'd0);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("clr.nopush", 32'(FIFO_COUNT), 32'd0);
        step(0, 0, 1, 8'h5A, 1, 0);
        chk("clr.packzero", FIFO_RD_DATA, 32'h0000_005A);

        // Simultaneous push and pop keeps the count and the order.
        step(1, 0, 0, 8'h00, 0, 0);
        sb.delete();
        push_words(5, 1);
        chk("pp.count_before", 32'(FIFO_COUNT), 32'd5);
        begin
            logic [31:0] w;
            w = $urandom;
            for (int b = 0; b < N - 1; b++) step(0, 0, 1, w[b*8 +: 8], 0, 0);
            chk("pp.head", FIFO_RD_DATA, sb[0]);
            step(0, 0, 1, w[31:24], 0, 1);
            void'(sb.pop_front());
            sb.push_back(w);
            chk("pp.count_after", 32'(FIFO_COUNT), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pp.order%0d", i), FIFO_RD_DATA, sb.pop_front());
            step(0, 0, 0, 8'h00, 0, 1);
        end
        chk("pp.drained", 32'(FIFO_EMPTY), 32'd1);

        // Reset mid-word discards the partial bytes.
        step(0, 0, 1, 8'hF1, 0, 0);
        step(0, 0, 1, 8'hF2, 0, 0);
        step(1, 0, 0, 8'h00, 0, 0);
        chk("rst.empty", 32'(FIFO_EMPTY), 32'd1);
        for (int b = 1; b <= N; b++) step(0, 0, 1, 8'(b), 0, 0);
        chk("rst.rdata", FIFO_RD_DATA, 32'h0403_0201);
        chk("rst.count", 32'(FIFO_COUNT), 32'd1);

        // Random traffic: a filling phase (rare reads) then a draining phase.
        for (int ph = 0; ph < 2; ph++) begin
            int rd_pct;
            rd_pct = (ph == 0) ? 10 : 60;
            for (int i = 0; i < 1500; i++) begin
                step($urandom_range(0, 999) < 2, $urandom_range(0, 999) < 2,
                     $urandom_range(0, 99) < 70, 8'($urandom),
                     $urandom_range(0, 99) < 5, $urandom_range(0, 99) < rd_pct);
                check_model("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
